countdown_datapath: RTL and testbench



---
 rtl/countdown_datapath_if.sv | 37 +++
 rtl/countdown_datapath.sv | 123 ++++++++++++
 tb/tb_countdown_datapath.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_datapath_if.sv
// ============================================================================
// Module      : countdown_datapath_if
// Description : Signal bundle between the timer controller and the countdown
//               datapath. It carries the switch value, the preview and set
//               strobes, the run enable, the four BCD display digits, and the
//               isTimeFlat status.
//   master : controller side; drives sw/enables/strobes, reads digits/status
//   slave  : datapath side; reads sw/enables/strobes, drives digits/status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface countdown_datapath_if;
  logic [7:0] sw;
  logic       swSecEn;
  logic       swMinEn;
  logic       secsSet;
  logic       minsSet;
  logic       decEn;
  logic [3:0] minTens;
  logic [3:0] minOnes;
  logic [3:0] secTens;
  logic [3:0] secOnes;
  logic       isTimeFlat;

  modport master (
    output sw, swSecEn, swMinEn, secsSet, minsSet, decEn,
    input  minTens, minOnes, secTens, secOnes, isTimeFlat
  );

  modport slave (
    input  sw, swSecEn, swMinEn, secsSet, minsSet, decEn,
    output minTens, minOnes, secTens, secOnes, isTimeFlat
  );
endinterface

`default_nettype wire

// File: rtl/countdown_datapath.sv
// ============================================================================
// Module      : countdown_datapath
// Description : BCD minutes/seconds countdown register pair with a one-second
//               prescaler, switch validation, a registered display mux, and a
//               registered time-is-zero flag.
//   clk    in  : system clock, rising edge
//   reset  in  : asynchronous, active-low reset
//   bus    slave modport of countdown_datapath_if:
//          sw[7:4]/sw[3:0] BCD tens/ones, swSecEn/swMinEn preview enables,
//          secsSet/minsSet load strobes, decEn run enable,
//          minTens/minOnes/secTens/secOnes display digits, isTimeFlat status
// Parameter   : TICK_DIV - clock cycles per decrement tick (>= 2)
// Option      : COUNTDOWN_CLAMP_EN - when defined, out-of-range switch digits
//               saturate to their maximum; otherwise the field is rejected.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_datapath #(
  parameter int TICK_DIV = 50000000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  countdown_datapath_if.slave bus
);

  localparam int              CNT_W  = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(TICK_DIV - 1);

  logic [7:0]       sec_q;      // stored seconds, BCD
  logic [7:0]       min_q;      // stored minutes, BCD
  logic [CNT_W-1:0] p_q;        // prescaler
  logic [7:0]       sec_disp_q;
  logic [7:0]       min_disp_q;
  logic             flat_q;

  // --------------------------------------------------------------------------
  // Switch validation
  // --------------------------------------------------------------------------
  logic [7:0] vsec, vmin;
  logic       sec_ok, min_ok;

  always_comb begin
    vsec   = bus.sw;
    vmin   = bus.sw;
    sec_ok = 1'b1;
    min_ok = 1'b1;
`ifdef COUNTDOWN_CLAMP_EN
    if (bus.sw[7:4] > 4'd5) vsec[7:4] = 4'd5;
    if (bus.sw[3:0] > 4'd9) vsec[3:0] = 4'd9;
    if (bus.sw[7:4] > 4'd9) vmin[7:4] = 4'd9;
    if (bus.sw[3:0] > 4'd9) vmin[3:0] = 4'd9;
`else
    sec_ok = (bus.sw[7:4] <= 4'd5) && (bus.sw[3:0] <= 4'd9);
    min_ok = (bus.sw[7:4] <= 4'd9) && (bus.sw[3:0] <= 4'd9);
`endif
  end

  logic load_sec, load_min;
  assign load_sec = bus.secsSet && sec_ok;
  assign load_min = bus.minsSet && min_ok;

  // --------------------------------------------------------------------------
  // Prescaler tick and BCD borrow chain
  // --------------------------------------------------------------------------
  logic tick, time_zero, dec_go;
  assign tick      = bus.decEn && (p_q == P_LAST);
  assign time_zero = (sec_q == 8'h00) && (min_q == 8'h00);
  assign dec_go    = tick && !time_zero;

  logic [7:0] sec_dec, min_dec;
  logic       b_s_ones, b_s_tens, b_m_ones;

  always_comb begin
    b_s_ones     = (sec_q[3:0] == 4'd0);
    b_s_tens     = b_s_ones && (sec_q[7:4] == 4'd0);
    b_m_ones     = b_s_tens && (min_q[3:0] == 4'd0);
    sec_dec[3:0] = b_s_ones ? 4'd9 : sec_q[3:0] - 4'd1;
    sec_dec[7:4] = !b_s_ones ? sec_q[7:4] :
                   (b_s_tens ? 4'd5 : sec_q[7:4] - 4'd1);
    min_dec[3:0] = !b_s_tens ? min_q[3:0] :
                   (b_m_ones ? 4'd9 : min_q[3:0] - 4'd1);
    // minTens can only underflow at 00:00, which dec_go already excludes
    min_dec[7:4] = b_m_ones ? min_q[7:4] - 4'd1 : min_q[7:4];
  end

  // A load overrides the tick for its own field only; the other field still
  // takes its decremented value.
  logic [7:0] sec_nxt, min_nxt;
  assign sec_nxt = load_sec ? vsec : (dec_go ? sec_dec : sec_q);
  assign min_nxt = load_min ? vmin : (dec_go ? min_dec : min_q);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      p_q        <= '0;
      sec_disp_q <= 8'h00;
      min_disp_q <= 8'h00;
      flat_q     <= 1'b1;
    end else begin
      sec_q      <= sec_nxt;
      min_q      <= min_nxt;
      p_q        <= (!bus.decEn || p_q == P_LAST) ? '0 : p_q + 1'b1;
      // A rejected switch value falls back to showing the stored register
      sec_disp_q <= (bus.swSecEn && sec_ok) ? vsec : sec_q;
      min_disp_q <= (bus.swMinEn && min_ok) ? vmin : min_q;
      flat_q     <= (sec_nxt == 8'h00) && (min_nxt == 8'h00);
    end
  end

  assign bus.secTens    = sec_disp_q[7:4];
  assign bus.secOnes    = sec_disp_q[3:0];
  assign bus.minTens    = min_disp_q[7:4];
  assign bus.minOnes    = min_disp_q[3:0];
  assign bus.isTimeFlat = flat_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown_datapath.sv
// ============================================================================
// Module      : tb_countdown_datapath
// Description : Self-checking bench for countdown_datapath with TICK_DIV=4.
//               Reference model keeps time as plain integers (total seconds)
//               and the display as decimal values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_datapath;

  localparam int TICK = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  countdown_datapath_if bus();

  countdown_datapath #(.TICK_DIV(TICK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // model state, decimal
  int mS = 0, mM = 0, mP = 0, mdS = 0, mdM = 0;
  bit mflat = 1'b1;

  function automatic bit val_field(input logic [7:0] b, input int tmax, output int v);
    int t, o;
    t = int'(b[7:4]);
    o = int'(b[3:0]);
`ifdef COUNTDOWN_CLAMP_EN
    if (t > tmax) t = tmax;
    if (o > 9) o = 9;
    v = t * 10 + o;
    return 1'b1;
`else
    v = t * 10 + o;
    return (t <= tmax) && (o <= 9);
`endif
  endfunction

  function automatic logic [15:0] exp_disp();
    return {4'(mdM / 10), 4'(mdM % 10), 4'(mdS / 10), 4'(mdS % 10)};
  endfunction

  function automatic logic [15:0] dut_disp();
    return {bus.minTens, bus.minOnes, bus.secTens, bus.secOnes};
  endfunction

  task automatic model_reset();
    mS = 0; mM = 0; mP = 0; mdS = 0; mdM = 0; mflat = 1'b1;
  endtask

  // One clock edge with the currently driven inputs; model advances alongside.
  task automatic step();
    bit so, mo, tk;
    int sv, mv, t, td, nS, nM;
    so = val_field(bus.sw, 5, sv);
    mo = val_field(bus.sw, 9, mv);
    @(posedge clk);
    tk  = bus.decEn && (mP == TICK - 1);
    mP  = bus.decEn ? (mP + 1) % TICK : 0;
    mdS = (bus.swSecEn && so) ? sv : mS;
    mdM = (bus.swMinEn && mo) ? mv : mM;
    t   = mM * 60 + mS;
    td  = (t > 0) ? t - 1 : 0;
    nS  = (bus.secsSet && so) ? sv : (tk ? td % 60 : mS);
    nM  = (bus.minsSet && mo) ? mv : (tk ? td / 60 : mM);
    mS  = nS;
    mM  = nM;
    mflat = (nS == 0) && (nM == 0);
    #1;
  endtask

  task automatic idle_inputs();
    bus.sw = 8'h00; bus.swSecEn = 0; bus.swMinEn = 0;
    bus.secsSet = 0; bus.minsSet = 0; bus.decEn = 0;
  endtask

  // Load MM:SS (BCD) with the countdown stopped, then let the display settle.
  task automatic load_time(input logic [7:0] m, input logic [7:0] s);
    idle_inputs();
    bus.sw = s; bus.secsSet = 1; step();
    bus.secsSet = 0; bus.sw = m; bus.minsSet = 1; step();
    bus.minsSet = 0; step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #12;
    n_checks++;
    if (dut_disp() !== 16'h0000) begin
      n_err++; $display("FAIL reset_display: got %h expected 0000", dut_disp());
    end
    n_checks++;
    if (bus.isTimeFlat !== 1'b1) begin
      n_err++; $display("FAIL reset_flat: got %b expected 1", bus.isTimeFlat);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    load_time(8'h03, 8'h27);
    n_checks++;
    if (dut_disp() !== 16'h0327) begin
      n_err++; $display("FAIL reset_preload: got %h expected 0327", dut_disp());
    end
    bus.decEn = 1;
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_disp() !== 16'h0000) begin
      n_err++; $display("FAIL reset_async_display: got %h expected 0000", dut_disp());
    end
    n_checks++;
    if (bus.isTimeFlat !== 1'b1) begin
      n_err++; $display("FAIL reset_async_flat: got %b expected 1", bus.isTimeFlat);
    end
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_preview();
    idle_inputs();
    bus.sw = 8'h45; bus.swSecEn = 1; bus.secsSet = 1; step();
    bus.secsSet = 0; step();
    n_checks++;
    if (dut_disp()[7:0] !== 8'h45) begin
      n_err++; $display("FAIL preview_secs: got %h expected 45", dut_disp()[7:0]);
    end
    bus.swSecEn = 0; bus.sw = 8'h02; bus.minsSet = 1; step();
    bus.minsSet = 0; step();
    n_checks++;
    if (dut_disp() !== 16'h0245 || dut_disp() !== exp_disp()) begin
      n_err++; $display("FAIL load_display: got %h expected 0245 (model %h)", dut_disp(), exp_disp());
    end
    n_checks++;
    if (bus.isTimeFlat !== 1'b0) begin
      n_err++; $display("FAIL load_flat: got %b expected 0", bus.isTimeFlat);
    end
  endtask

  task automatic test_borrow();
    load_time(8'h10, 8'h00);
    bus.decEn = 1;
    for (int i = 1; i <= 9; i++) begin
      step();
      n_checks++;
      if (dut_disp() !== exp_disp() || bus.isTimeFlat !== mflat) begin
        n_err++; $display("FAIL borrow_cycle%0d: got %h/%b expected %h/%b",
                          i, dut_disp(), bus.isTimeFlat, exp_disp(), mflat);
      end
      if (i == 5) begin
        n_checks++;
        if (dut_disp() !== 16'h0959) begin
          n_err++; $display("FAIL borrow_first_tick: got %h expected 0959", dut_disp());
        end
      end
      if (i == 9) begin
        n_checks++;
        if (dut_disp() !== 16'h0958) begin
          n_err++; $display("FAIL borrow_second_tick: got %h expected 0958", dut_disp());
        end
      end
    end
  endtask

  task automatic test_terminal();
    load_time(8'h00, 8'h02);
    bus.decEn = 1;
    for (int i = 1; i <= 28; i++) begin
      step();
      n_checks++;
      if (dut_disp() !== exp_disp() || bus.isTimeFlat !== mflat) begin
        n_err++; $display("FAIL terminal_cycle%0d: got %h/%b expected %h/%b",
                          i, dut_disp(), bus.isTimeFlat, exp_disp(), mflat);
      end
      if (i == 8) begin
        n_checks++;
        if (bus.isTimeFlat !== 1'b1) begin
          n_err++; $display("FAIL terminal_flat: got %b expected 1", bus.isTimeFlat);
        end
      end
    end
    n_checks++;
    if (dut_disp() !== 16'h0000) begin
      n_err++; $display("FAIL terminal_hold: got %h expected 0000", dut_disp());
    end
  endtask

  task automatic test_pause();
    load_time(8'h05, 8'h00);
    bus.decEn = 1; step(); step();
    bus.decEn = 0; step();
    bus.decEn = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_checks++;
      if (dut_disp() !== exp_disp()) begin
        n_err++; $display("FAIL pause_cycle%0d: got %h expected %h", i, dut_disp(), exp_disp());
      end
      if (i == 4) begin
        n_checks++;
        if (dut_disp() !== 16'h0500) begin
          n_err++; $display("FAIL pause_early_tick: got %h expected 0500", dut_disp());
        end
      end
    end
    n_checks++;
    if (dut_disp() !== 16'h0459) begin
      n_err++; $display("FAIL pause_full_second: got %h expected 0459", dut_disp());
    end
  endtask

  task automatic test_invalid();
    logic [7:0] exp_s, exp_m;
    load_time(8'h12, 8'h30);
    bus.sw = 8'h7B; bus.secsSet = 1; bus.swSecEn = 1; step();
    bus.secsSet = 0; step();
`ifdef COUNTDOWN_CLAMP_EN
    exp_s = 8'h59;
`else
    exp_s = 8'h30;
`endif
    n_checks++;
    if (dut_disp()[7:0] !== exp_s || dut_disp() !== exp_disp()) begin
      n_err++; $display("FAIL invalid_secs: got %h expected %h", dut_disp()[7:0], exp_s);
    end
    bus.swSecEn = 0; step();
    n_checks++;
    if (dut_disp()[7:0] !== exp_s) begin
      n_err++; $display("FAIL invalid_secs_stored: got %h expected %h", dut_disp()[7:0], exp_s);
    end
    bus.sw = 8'hA5; bus.minsSet = 1; step();
    bus.minsSet = 0; step();
`ifdef COUNTDOWN_CLAMP_EN
    exp_m = 8'h95;
`else
    exp_m = 8'h12;
`endif
    n_checks++;
    if (dut_disp()[15:8] !== exp_m || dut_disp() !== exp_disp()) begin
      n_err++; $display("FAIL invalid_mins: got %h expected %h", dut_disp()[15:8], exp_m);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8)
        bus.sw = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        bus.sw = 8'($urandom);
      bus.swSecEn = ($urandom_range(0, 9) < 3);
      bus.swMinEn = ($urandom_range(0, 9) < 3);
      bus.secsSet = ($urandom_range(0, 19) == 0);
      bus.minsSet = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) bus.decEn = ~bus.decEn;
      step();
      n_checks++;
      if (dut_disp() !== exp_disp() || bus.isTimeFlat !== mflat) begin
        n_err++; $display("FAIL random_cycle%0d: got %h/%b expected %h/%b",
                          i, dut_disp(), bus.isTimeFlat, exp_disp(), mflat);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_preview();
    test_borrow();
    test_terminal();
    test_pause();
    test_invalid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
